// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // The watchdog counter only has to reach TIMEOUT_CYC-1.
    function automatic int cnt_width(input int timeout_cyc);
        return $clog2(timeout_cyc);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bundle of the arbiter.
// Handshake: a requester holds req (with wr/addr/wdata stable) until its one-cycle req_done; mem_en is a one-cycle issue pulse and mem_done is the memory's one-cycle completion.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_err;
    logic [DATA_W-1:0]         req_rdata;
    logic                      busy;
    logic                      mem_en;
    logic                      mem_wr;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W-1:0]         mem_data_out;
    logic                      mem_stall;
    logic                      mem_done;

    modport master (
        input  req, req_wr, req_addr, req_wdata, mem_data_out, mem_stall, mem_done,
        output req_done, req_err, req_rdata, busy, mem_en, mem_wr, mem_addr, mem_data_in
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, mem_data_out, mem_stall, mem_done,
        input  req_done, req_err, req_rdata, busy, mem_en, mem_wr, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Rotate-priority encoder: first set request at or above the pointer, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_any_req,
    output logic [IDX_W-1:0]   o_winner
);

    int w_idx;

    // Scan from farthest to nearest so the nearest set bit overwrites the rest.
    always_comb begin
        o_any_req = |i_req;
        o_winner  = '0;
        w_idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = (int'(i_rr_ptr) + i) % NUM_REQ;
            if (i_req[w_idx[IDX_W-1:0]]) o_winner = w_idx[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem_system port among NUM_REQ requesters,
// one transaction at a time, with a watchdog that aborts a missing mem_done.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.master     bus,
    output arb_state_t        o_dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t          r_state, w_next_state;
    logic [IDX_W-1:0]    r_rr_ptr, r_gnt_idx;
    logic                r_mem_wr, r_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata, r_rdata;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_any_req;
    logic [IDX_W-1:0]    w_winner;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [NUM_REQ-1:0]  w_done;
    logic                w_unused_stall;

    // mem_stall is informational; sequencing relies on mem_done alone.
    assign w_unused_stall = bus.mem_stall;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .i_req     (bus.req),
        .i_rr_ptr  (r_rr_ptr),
        .o_any_req (w_any_req),
        .o_winner  (w_winner)
    );

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_sel_wr    = bus.req_wr[i];
                w_sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ISSUE;
            ISSUE:   w_next_state = bus.mem_done ? RESP : WAIT;
            WAIT:    if (bus.mem_done || (r_cnt == CNT_LAST)) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt_idx   <= w_winner;
                        r_mem_wr    <= w_sel_wr;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                    if (bus.mem_done) r_rdata <= bus.mem_data_out;
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.mem_done) begin
                        r_rdata <= bus.mem_data_out;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                RESP: begin
                    r_rr_ptr <= (r_gnt_idx == IDX_LAST) ? '0 : r_gnt_idx + IDX_W'(1);
                    r_err    <= 1'b0;
                    r_rdata  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_done[i] = (r_state == RESP) && (r_gnt_idx == IDX_W'(i));
        end
    end

    assign bus.req_done    = w_done;
    assign bus.req_err     = w_done & {NUM_REQ{r_err}};
    assign bus.req_rdata   = r_rdata;
    assign bus.busy        = (r_state != IDLE);
    assign bus.mem_en      = (r_state == ISSUE);
    assign bus.mem_wr      = r_mem_wr;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_data_in = r_mem_wdata;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two requesters, 16-cycle watchdog.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();
    arb_state_t dbg_state;

    mem_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_tab[NREQ];
    logic [31:0] wdata_tab[NREQ];
    logic        wr_tab[NREQ];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        addr_tab[idx]  = addr;
        wdata_tab[idx] = wd;
        wr_tab[idx]    = wr;
        bus.req_wr[idx]              = wr;
        bus.req_addr[idx*AW +: AW]   = addr;
        bus.req_wdata[idx*DW +: DW]  = wd;
        bus.req[idx]                 = 1'b1;
    endtask

    // Serve the next expected grant: memory answers 'delay' cycles after mem_en.
    task automatic serve(input int delay, input logic [31:0] data, output int lat);
        int idx;
        int n;
        logic [NREQ-1:0] exp_done;
        idx = 0;
        n   = 0;
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) idx = int'(exp_q.pop_front());
        while (bus.mem_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        lat = n;
        check_eq("mem_en_seen", 64'(bus.mem_en), 64'(1));
        check_eq("grant_addr", 64'(bus.mem_addr), 64'(addr_tab[idx]));
        check_eq("grant_wr", 64'(bus.mem_wr), 64'(wr_tab[idx]));
        if (wr_tab[idx]) check_eq("grant_wdata", 64'(bus.mem_data_in), 64'(wdata_tab[idx]));
        check_eq("busy_issue", 64'(bus.busy), 64'(1));
        if (delay > 0) begin
            tick();
            check_eq("mem_en_one_cycle", 64'(bus.mem_en), 64'(0));
            for (int i = 1; i < delay; i++) begin
                check_eq("hold_addr", 64'(bus.mem_addr), 64'(addr_tab[idx]));
                check_eq("no_reissue", 64'(bus.mem_en), 64'(0));
                tick();
            end
        end
        bus.mem_done     = 1'b1;
        bus.mem_data_out = data;
        check_eq("hold_addr_done", 64'(bus.mem_addr), 64'(addr_tab[idx]));
        check_eq("hold_wr_done", 64'(bus.mem_wr), 64'(wr_tab[idx]));
        if (wr_tab[idx]) check_eq("hold_wdata_done", 64'(bus.mem_data_in), 64'(wdata_tab[idx]));
        check_eq("no_early_done", 64'(bus.req_done), 64'(0));
        tick();
        bus.mem_done     = 1'b0;
        bus.mem_data_out = '0;
        exp_done         = '0;
        exp_done[idx]    = 1'b1;
        check_eq("req_done", 64'(bus.req_done), 64'(exp_done));
        check_eq("req_err_clear", 64'(bus.req_err), 64'(0));
        check_eq("req_rdata", 64'(bus.req_rdata), 64'(data));
        check_eq("state_resp", 64'(dbg_state), 64'(RESP));
        bus.req[idx] = 1'b0;
        tick();
        check_eq("done_one_cycle", 64'(bus.req_done), 64'(0));
        check_eq("rdata_cleared", 64'(bus.req_rdata), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        logic seen;
        bus.req          = '0;
        bus.req_wr       = '0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_data_out = '0;
        bus.mem_stall    = 1'b0;
        bus.mem_done     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            addr_tab[i] = '0; wdata_tab[i] = '0; wr_tab[i] = 1'b0;
        end

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
        check_eq("rst_busy", 64'(bus.busy), 64'(0));
        check_eq("rst_mem_en", 64'(bus.mem_en), 64'(0));
        check_eq("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check_eq("rst_mem_data_in", 64'(bus.mem_data_in), 64'(0));
        check_eq("rst_req_rdata", 64'(bus.req_rdata), 64'(0));
        check_eq("rst_req_done", 64'(bus.req_done), 64'(0));
        rst_n = 1'b1;
        tick();

        // mem_done while idle is ignored
        bus.mem_done     = 1'b1;
        bus.mem_data_out = 32'hFFFF_0000;
        tick();
        check_eq("idle_done_busy", 64'(bus.busy), 64'(0));
        check_eq("idle_done_req_done", 64'(bus.req_done), 64'(0));
        bus.mem_done     = 1'b0;
        bus.mem_data_out = '0;
        tick();
        check_eq("idle_done_rdata", 64'(bus.req_rdata), 64'(0));

        // Contention: both rise together, twice -> 0,1,0,1
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0);
        exp_q.push_back(0); exp_q.push_back(1);
        serve(2, 32'h1111_0000, lat);
        serve(1, 32'h2222_0000, lat);
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0);
        exp_q.push_back(0); exp_q.push_back(1);
        serve(3, 32'h3333_0000, lat);
        serve(0, 32'h4444_0000, lat);

        // Single read, mem_done 4 cycles after mem_en
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        exp_q.push_back(0);
        serve(4, 32'hDEAD_BEEF, lat);
        check_eq("read_latency", 64'(lat), 64'(1));

        // Write from requester 1
        set_req(1, 1'b1, 32'h0000_0040, 32'h1234_5678);
        exp_q.push_back(1);
        serve(3, 32'hCAFE_0000, lat);
        bus.req_wr[1] = 1'b0;
        wr_tab[1]     = 1'b0;

        // Fairness: requester 0 re-requests at once, requester 1 still wins next
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0);
        exp_q.push_back(0);
        serve(1, 32'h5555_0000, lat);
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        exp_q.push_back(1); exp_q.push_back(0);
        serve(1, 32'h6666_0000, lat);
        serve(1, 32'h7777_0000, lat);

        // Timeout: no mem_done, memory drives garbage that must not leak out
        set_req(0, 1'b0, 32'h0000_0300, 32'h0);
        bus.mem_data_out = 32'hBADB_AD00;
        n = 0;
        while (bus.mem_en !== 1'b1 && n < 20) begin tick(); n++; end
        check_eq("to_mem_en", 64'(bus.mem_en), 64'(1));
        n = 0;
        while (bus.req_done == '0 && n < 40) begin tick(); n++; end
        check_eq("to_latency", 64'(n), 64'(17));
        check_eq("to_req_done", 64'(bus.req_done), 64'(2'b01));
        check_eq("to_req_err", 64'(bus.req_err), 64'(2'b01));
        check_eq("to_rdata", 64'(bus.req_rdata), 64'(0));
        bus.req[0]       = 1'b0;
        bus.mem_data_out = '0;
        tick();
        check_eq("to_err_one_cycle", 64'(bus.req_err), 64'(0));
        set_req(0, 1'b0, 32'h0000_0300, 32'h0);
        exp_q.push_back(0);
        serve(2, 32'h55AA_55AA, lat);

        // Reset mid-WAIT while requester 1 (write) is being served
        set_req(1, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5);
        n = 0;
        while (bus.mem_en !== 1'b1 && n < 20) begin tick(); n++; end
        check_eq("rw_mem_en", 64'(bus.mem_en), 64'(1));
        tick();
        tick();
        check_eq("rw_in_wait", 64'(dbg_state), 64'(WAIT));
        rst_n = 1'b0;
        #1;
        check_eq("rw_state", 64'(dbg_state), 64'(IDLE));
        check_eq("rw_busy", 64'(bus.busy), 64'(0));
        check_eq("rw_mem_addr", 64'(bus.mem_addr), 64'(0));
        check_eq("rw_mem_wr", 64'(bus.mem_wr), 64'(0));
        check_eq("rw_mem_data_in", 64'(bus.mem_data_in), 64'(0));
        bus.req       = '0;
        bus.req_wr    = '0;
        wr_tab[1]     = 1'b0;
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | (|bus.req_done);
            tick();
        end
        check_eq("rw_no_done", 64'(seen), 64'(0));
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0);
        exp_q.push_back(0); exp_q.push_back(1);
        serve(1, 32'h0BAD_F00D, lat);
        serve(2, 32'h600D_F00D, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single mem_system CPU-side port (en/wr/addr/data_in, data_out/stall/done) between NUM_REQ requesters, e.g. instruction fetch, load/store and an accelerator.
- Round-robin arbitration with one outstanding transaction at a time.
- Registered request to memory, registered response to the winner.
- Watchdog returns an error if mem_done never arrives.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 1024, max cycles in WAIT before abort (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; one clock domain, all flops reset asynchronously on rst_n low.
- req  in  NUM_REQ  per-requester request; held high until that requester's req_done.
- req_wr  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed per-requester address.
- req_wdata  in  NUM_REQ*DATA_W  packed per-requester write data.
- req_done  out  NUM_REQ  one-cycle completion pulse, one-hot or zero.
- req_err  out  NUM_REQ  one-cycle timeout flag, coincident with req_done.
- req_rdata  out  DATA_W  read data; valid only in req_done cycle.
- busy  out  1  high whenever state != IDLE.
- mem_en  out  1  one-cycle issue pulse to mem_system.
- mem_wr  out  1  write strobe; held through the transaction.
- mem_addr  out  ADDR_W  latched address; held through the transaction.
- mem_data_in  out  DATA_W  latched write data; held through the transaction.
- mem_data_out  in  DATA_W  mem_system read data.
- mem_stall  in  1  mem_system busy; informational only, not used for sequencing.
- mem_done  in  1  mem_system completion.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, gnt_idx=0. All outputs 0, including mem_addr, mem_data_in and req_rdata. Reset mid-transaction abandons it silently; no done or err is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, select the winner by round-robin: first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch gnt_idx, wr, addr and wdata into mem_* registers, then go to ISSUE.
  - If no req is set, stay in IDLE.
- ISSUE:
  - mem_en=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - If mem_done is already high in ISSUE, treat as WAIT-done: capture data and go to RESP.
- WAIT:
  - mem_en=0; mem_wr/addr/data_in stay stable; counter increments.
  - mem_done=1: capture mem_data_out into req_rdata (reads and writes alike), go to RESP.
  - Counter reaches TIMEOUT_CYC-1 without mem_done: set err flag, req_rdata=0, go to RESP.
- RESP:
  - req_done[gnt_idx]=1; req_err[gnt_idx]=err flag.
  - rr_ptr = (gnt_idx+1) mod NUM_REQ; clear err; go to IDLE.
  - req_rdata is cleared in the following cycle.
- Requester protocol: the served requester drops req at the edge ending RESP. Any req high in IDLE is a new request. A req dropped before RESP does not cancel the transaction; req_done still pulses.
- Latency:
  - req high in cycle 0 (IDLE): mem_en in cycle 1.
  - mem_done in cycle k: req_done in cycle k+1.
  - Minimum 3 cycles req-to-done; next grant no earlier than the cycle after RESP.
- Simultaneous requests: exactly one winner; losers hold req and wait. A requester waits at most NUM_REQ-1 transactions.
- A mem_done outside WAIT/ISSUE is ignored.
- A second mem_done in the same transaction is ignored, because the FSM has already left WAIT.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP};
  - default ADDR_W, DATA_W and TIMEOUT_CYC localparams;
  - a function to compute the timeout counter width, $clog2(TIMEOUT_CYC).
- One sub-module, rr_picker: combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_req, winner index.
- FSM, latches and watchdog stay in mem_arbiter.

Test Plan:
- Single read: req[0]=1, addr=0x0000_0100, mem_done 4 cycles after mem_en with data 0xDEADBEEF → mem_en exactly 1 cycle; mem_addr=0x100 held; req_done[0] one cycle later; req_rdata=0xDEADBEEF; req_err=0.
- Contention: req[0] and req[1] rise in the same cycle, both held → grants in order 0, 1. Re-raising both gives order 0, 1 again with rr_ptr=0 after serving 1. Never two mem_en pulses without an intervening RESP.
- Fairness: req[0] continuously re-requests, req[1] waiting → req[1] is served after at most one req[0] transaction.
- Write: req_wr[1]=1, addr 0x40, wdata 0x12345678 → mem_wr=1 and mem_data_in=0x12345678 stable from ISSUE through the mem_done cycle; req_done[1] pulses.
- Timeout: TIMEOUT_CYC=16, mem_done never asserted → req_done[0] and req_err[0] high together, 17 cycles after mem_en; req_rdata=0; next request is served normally.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT → all outputs 0 immediately; no req_done; post-reset arbitration starts at requester 0.
